// File: rtl/ahb_decoder_mux.sv
// ahb_decoder_mux: AHB-Lite address decoder and response multiplexor for one
// manager, NUM_SUBS mapped subordinates and a default subordinate.
// Optional decode-error log enabled by defining AHB_DECODE_ERR_LOG_EN.
module ahb_decoder_mux #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_SUBS   = 4,
   parameter logic [NUM_SUBS*ADDR_WIDTH-1:0] SUB_BASE = {32'h3000_0000, 32'h2000_0000,
                                                         32'h1000_0000, 32'h0000_0000},
   parameter logic [NUM_SUBS*ADDR_WIDTH-1:0] SUB_MASK = {32'hF000_0000, 32'hF000_0000,
                                                         32'hF000_0000, 32'hF000_0000}
) (
   input  logic                         HCLK,
   input  logic                         HRESETn,
   input  logic [ADDR_WIDTH-1:0]        HADDR,
   input  logic [1:0]                   HTRANS,
   output logic [NUM_SUBS-1:0]          HSEL,
   output logic                         HSEL_DEF,
   input  logic [NUM_SUBS*DATA_WIDTH-1:0] HRDATA_S,
   input  logic [NUM_SUBS*2-1:0]        HRESP_S,
   input  logic [NUM_SUBS-1:0]          HREADYOUT_S,
   input  logic [DATA_WIDTH-1:0]        HRDATA_DEF,
   input  logic [1:0]                   HRESP_DEF,
   input  logic                         HREADYOUT_DEF,
   output logic [DATA_WIDTH-1:0]        HRDATA,
   output logic [1:0]                   HRESP,
   output logic                         HREADY
`ifdef AHB_DECODE_ERR_LOG_EN
   ,
   output logic [15:0]                  DEC_ERR_CNT,
   output logic [ADDR_WIDTH-1:0]        DEC_ERR_ADDR
`endif
);

   localparam int unsigned IDX_W = (NUM_SUBS > 1) ? $clog2(NUM_SUBS) : 1;

   typedef enum logic [1:0] {
      PH_NONE,
      PH_SUB,
      PH_DEF
   } phase_t;

   phase_t                state, state_nxt;
   logic [IDX_W-1:0]      dp_idx, dp_idx_nxt;

   logic [NUM_SUBS-1:0]   match;
   logic [NUM_SUBS-1:0]   sel;
   logic [IDX_W-1:0]      hit_idx;
   logic                  hit;
   logic                  ready;
   logic                  unused_htrans0;

   // HTRANS[0] only distinguishes NONSEQ/SEQ or IDLE/BUSY; decode needs HTRANS[1] alone
   assign unused_htrans0 = HTRANS[0];

   // Raw per-slot address comparison
   always_comb begin
      match = '0;
      for (int unsigned i = 0; i < NUM_SUBS; i++) begin
         match[i] = ((HADDR & SUB_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])
                     == SUB_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]);
      end
   end

   // Priority pick: lowest matching slot wins, giving a one-hot or zero select
   always_comb begin
      sel     = '0;
      hit_idx = '0;
      hit     = 1'b0;
      for (int unsigned i = 0; i < NUM_SUBS; i++) begin
         if (match[i] && !hit) begin
            sel[i]  = 1'b1;
            hit_idx = i[IDX_W-1:0];
            hit     = 1'b1;
         end
      end
   end

   assign HSEL     = sel;
   assign HSEL_DEF = ~|match & HTRANS[1];

   // Data-phase owner register; async clear aborts any data phase in flight
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state  <= PH_NONE;
         dp_idx <= '0;
      end else begin
         state  <= state_nxt;
         dp_idx <= dp_idx_nxt;
      end
   end

   // Next data-phase owner: advance only on an accepted cycle, hold during wait states
   always_comb begin
      state_nxt  = state;
      dp_idx_nxt = dp_idx;
      if (ready) begin
         if (HSEL_DEF) begin
            state_nxt  = PH_DEF;
            dp_idx_nxt = '0;
         end else if (hit && HTRANS[1]) begin
            state_nxt  = PH_SUB;
            dp_idx_nxt = hit_idx;
         end else begin
            state_nxt  = PH_NONE;
            dp_idx_nxt = '0;
         end
      end
   end

   // Response mux driven only by the registered data-phase owner
   always_comb begin
      HRDATA = '0;
      HRESP  = 2'b00;
      ready  = 1'b1;
      case (state)
         PH_SUB: begin
            for (int unsigned i = 0; i < NUM_SUBS; i++) begin
               if (dp_idx == i[IDX_W-1:0]) begin
                  HRDATA = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
                  HRESP  = HRESP_S[i*2 +: 2];
                  ready  = HREADYOUT_S[i];
               end
            end
         end
         PH_DEF: begin
            HRDATA = HRDATA_DEF;
            HRESP  = HRESP_DEF;
            ready  = HREADYOUT_DEF;
         end
         default: begin
            HRDATA = '0;
            HRESP  = 2'b00;
            ready  = 1'b1;
         end
      endcase
   end

   assign HREADY = ready;

`ifdef AHB_DECODE_ERR_LOG_EN
   // Count and record accepted address phases that fall through to the default subordinate
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         DEC_ERR_CNT  <= '0;
         DEC_ERR_ADDR <= '0;
      end else if (ready && HSEL_DEF) begin
         if (DEC_ERR_CNT != 16'hFFFF) begin
            DEC_ERR_CNT <= DEC_ERR_CNT + 16'd1;
         end
         DEC_ERR_ADDR <= HADDR;
      end
   end
`endif

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Directed bench for ahb_decoder_mux; slot 3 is remapped so that it overlaps
// slot 2 (lowest slot must win). Error-log checks run when AHB_DECODE_ERR_LOG_EN is set.
module tb_ahb_decoder_mux;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned NS = 4;

   logic            HCLK = 1'b0;
   logic            HRESETn;
   logic [AW-1:0]   HADDR;
   logic [1:0]      HTRANS;
   logic [NS-1:0]   HSEL;
   logic            HSEL_DEF;
   logic [NS*DW-1:0] HRDATA_S;
   logic [NS*2-1:0] HRESP_S;
   logic [NS-1:0]   HREADYOUT_S;
   logic [DW-1:0]   HRDATA_DEF;
   logic [1:0]      HRESP_DEF;
   logic            HREADYOUT_DEF;
   logic [DW-1:0]   HRDATA;
   logic [1:0]      HRESP;
   logic            HREADY;
`ifdef AHB_DECODE_ERR_LOG_EN
   logic [15:0]     DEC_ERR_CNT;
   logic [AW-1:0]   DEC_ERR_ADDR;
`endif

   int total = 0;
   int bad   = 0;

   always #5 HCLK = ~HCLK;

   ahb_decoder_mux #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .NUM_SUBS   (NS),
      .SUB_BASE   ({32'h2000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
      .SUB_MASK   ({32'hE000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000})
   ) dut (
      .HCLK          (HCLK),
      .HRESETn       (HRESETn),
      .HADDR         (HADDR),
      .HTRANS        (HTRANS),
      .HSEL          (HSEL),
      .HSEL_DEF      (HSEL_DEF),
      .HRDATA_S      (HRDATA_S),
      .HRESP_S       (HRESP_S),
      .HREADYOUT_S   (HREADYOUT_S),
      .HRDATA_DEF    (HRDATA_DEF),
      .HRESP_DEF     (HRESP_DEF),
      .HREADYOUT_DEF (HREADYOUT_DEF),
      .HRDATA        (HRDATA),
      .HRESP         (HRESP),
      .HREADY        (HREADY)
`ifdef AHB_DECODE_ERR_LOG_EN
      ,
      .DEC_ERR_CNT   (DEC_ERR_CNT),
      .DEC_ERR_ADDR  (DEC_ERR_ADDR)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   initial begin
      HRESETn       = 1'b0;
      HADDR         = 32'h0000_0000;
      HTRANS        = 2'b00;
      HRDATA_S      = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
      HRESP_S       = '0;
      HREADYOUT_S   = '1;
      HRDATA_DEF    = 32'hDEAD_BEEF;
      HRESP_DEF     = 2'b00;
      HREADYOUT_DEF = 1'b1;

      // reset state
      @(negedge HCLK);
      chk("rst_hready", 64'(HREADY), 64'h1);
      chk("rst_hresp",  64'(HRESP),  64'h0);
      chk("rst_hrdata", 64'(HRDATA), 64'h0);
      chk("rst_hsel",   64'(HSEL),   64'h1);
      chk("rst_hseldef", 64'(HSEL_DEF), 64'h0);
      HRESETn = 1'b1;
      tick();

      // NONSEQ to slot 2 (also overlaps slot 3, slot 2 must win)
      HADDR  = 32'h2000_0040;
      HTRANS = 2'b10;
      @(negedge HCLK);
      chk("s2_hsel",    64'(HSEL),     64'h4);
      chk("s2_hseldef", 64'(HSEL_DEF), 64'h0);
      tick();
      HADDR  = 32'hF000_0000;
      HTRANS = 2'b00;
      @(negedge HCLK);
      chk("s2_hrdata",  64'(HRDATA),   64'hCAFE_0002);
      chk("s2_hready",  64'(HREADY),   64'h1);
      chk("idle_hsel",  64'(HSEL),     64'h0);
      chk("idle_hseldef", 64'(HSEL_DEF), 64'h0);
      HTRANS = 2'b01;
      #1;
      chk("busy_hseldef", 64'(HSEL_DEF), 64'h0);
      HTRANS = 2'b00;
      tick();

      // IDLE data phase: no owner
      @(negedge HCLK);
      chk("none_hready", 64'(HREADY), 64'h1);
      chk("none_hresp",  64'(HRESP),  64'h0);
      chk("none_hrdata", 64'(HRDATA), 64'h0);

      // Unmapped NONSEQ, two-cycle ERROR from default subordinate
      tick();
      HADDR         = 32'hF000_0000;
      HTRANS        = 2'b10;
      HREADYOUT_DEF = 1'b0;
      HRESP_DEF     = 2'b01;
      @(negedge HCLK);
      chk("def_hsel",    64'(HSEL),     64'h0);
      chk("def_hseldef", 64'(HSEL_DEF), 64'h1);
      chk("def_pre_hresp", 64'(HRESP),  64'h0);
      tick();
      HTRANS = 2'b00;
      @(negedge HCLK);
      chk("err1_hready", 64'(HREADY), 64'h0);
      chk("err1_hresp",  64'(HRESP),  64'h1);
      chk("err1_hrdata", 64'(HRDATA), 64'hDEAD_BEEF);
      tick();
      HREADYOUT_DEF = 1'b1;
      @(negedge HCLK);
      chk("err2_hready", 64'(HREADY), 64'h1);
      chk("err2_hresp",  64'(HRESP),  64'h1);
      tick();
      HRESP_DEF = 2'b00;
      @(negedge HCLK);
      chk("post_err_hready", 64'(HREADY), 64'h1);
      chk("post_err_hresp",  64'(HRESP),  64'h0);

      // Sub0 with three wait states while next address targets sub3
      tick();
      HADDR          = 32'h0000_0100;
      HTRANS         = 2'b10;
      HREADYOUT_S[0] = 1'b0;
      @(negedge HCLK);
      chk("s0_hsel", 64'(HSEL), 64'h1);
      tick();
      HADDR = 32'h3000_0000;
      @(negedge HCLK);
      chk("s3_hsel",    64'(HSEL),   64'h8);
      chk("w1_hready",  64'(HREADY), 64'h0);
      chk("w1_hrdata",  64'(HRDATA), 64'hCAFE_0000);
      tick();
      @(negedge HCLK);
      chk("w2_hready",  64'(HREADY), 64'h0);
      chk("w2_hrdata",  64'(HRDATA), 64'hCAFE_0000);
      tick();
      @(negedge HCLK);
      chk("w3_hready",  64'(HREADY), 64'h0);
      tick();
      HREADYOUT_S[0] = 1'b1;
      @(negedge HCLK);
      chk("w_end_hready", 64'(HREADY), 64'h1);
      chk("w_end_hrdata", 64'(HRDATA), 64'hCAFE_0000);
      tick();
      HTRANS = 2'b00;
      @(negedge HCLK);
      chk("s3_hrdata", 64'(HRDATA), 64'hCAFE_0003);
      chk("s3_hready", 64'(HREADY), 64'h1);

`ifdef AHB_DECODE_ERR_LOG_EN
      chk("log_pre_cnt", 64'(DEC_ERR_CNT), 64'h1);
`endif

      // Reset asserted during a sub1 wait state
      tick();
      HADDR          = 32'h1000_0000;
      HTRANS         = 2'b10;
      HREADYOUT_S[1] = 1'b0;
      tick();
      HTRANS = 2'b00;
      @(negedge HCLK);
      chk("s1w_hready", 64'(HREADY), 64'h0);
      chk("s1w_hrdata", 64'(HRDATA), 64'hCAFE_0001);
      #1;
      HRESETn = 1'b0;
      #1;
      chk("arst_hready", 64'(HREADY), 64'h1);
      chk("arst_hresp",  64'(HRESP),  64'h0);
      chk("arst_hrdata", 64'(HRDATA), 64'h0);
`ifdef AHB_DECODE_ERR_LOG_EN
      chk("arst_cnt",  64'(DEC_ERR_CNT),  64'h0);
      chk("arst_addr", 64'(DEC_ERR_ADDR), 64'h0);
`endif
      HREADYOUT_S[1] = 1'b1;
      tick();
      HRESETn = 1'b1;

`ifdef AHB_DECODE_ERR_LOG_EN
      // Three accepted unmapped NONSEQs
      tick();
      HTRANS        = 2'b10;
      HRESP_DEF     = 2'b01;
      HREADYOUT_DEF = 1'b1;
      HADDR         = 32'hF000_0010;
      tick();
      HADDR = 32'hF000_0020;
      tick();
      HADDR = 32'hF000_0030;
      tick();
      HTRANS = 2'b00;
      @(negedge HCLK);
      chk("log_cnt",  64'(DEC_ERR_CNT),  64'h3);
      chk("log_addr", 64'(DEC_ERR_ADDR), 64'hF000_0030);
`endif

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
